// File: rtl/mux64_rr_arbiter_if.sv
// rtl/mux64_rr_arbiter_if.sv - four-requester to one-consumer stream bundle
//
// Purpose: groups the requester-side and consumer-side handshake and data
// signals of mux64_rr_arbiter into one bundle.
// Modports:
//   slave  - the arbiter: takes req_valid/y0..y3/out_ready,
//            drives req_ready/out_valid/out_data/out_sel.
//   master - the surrounding producers and consumer (mirror of slave).
// Signals:
//   req_valid [3:0]  bit i = requester i has a beat
//   y0..y3   [DW-1:0] requester data
//   req_ready [3:0]  bit i = beat from requester i accepted this cycle
//   out_valid        output register holds a beat
//   out_data [DW-1:0] registered selected data
//   out_sel  [1:0]   requester index that produced out_data
//   out_ready        consumer accepts out_data

interface mux64_rr_arbiter_if #(
   parameter int DW = 64
);
   logic [3:0]    req_valid;
   logic [DW-1:0] y0;
   logic [DW-1:0] y1;
   logic [DW-1:0] y2;
   logic [DW-1:0] y3;
   logic [3:0]    req_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    out_sel;
   logic          out_ready;

   modport slave (
      input  req_valid, y0, y1, y2, y3, out_ready,
      output req_ready, out_valid, out_data, out_sel
   );

   modport master (
      output req_valid, y0, y1, y2, y3, out_ready,
      input  req_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/mux64_rr_arbiter.sv
// rtl/mux64_rr_arbiter.sv - round-robin 4:1 arbiter with registered output stage
//
// Purpose: shares one DW-bit output channel between four requesters. The
// requester served last gets the lowest priority on the next decision. The
// selected beat lands in a single-entry output register that refills in the
// same cycle it drains, so a continuously ready consumer sees one beat per
// clock.
// Optional build macro: MUX_BURST_EN - once a requester wins, it keeps the
// channel for BURST_LEN beats (LOCK state) or until it drops req_valid.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux64_rr_arbiter_if.slave (requester and consumer handshakes)
// Parameters:
//   DW         data width per requester and output
//   BURST_LEN  beats per locked grant (1..255), only used with MUX_BURST_EN

module mux64_rr_arbiter #(
   parameter int DW        = 64,
   parameter int BURST_LEN = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mux64_rr_arbiter_if.slave     bus
);

   // The beat counter is 8 bits wide, so larger bursts cannot be tracked.
   if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_illegal_burst_len
      $error("mux64_rr_arbiter: BURST_LEN must be in 1..255");
   end

   logic          out_valid_q;
   logic [DW-1:0] out_data_q;
   logic [1:0]    out_sel_q;
   logic [1:0]    last_grant;

   logic          accept_en;
   logic [1:0]    gnt;
   logic          gnt_found;
   logic          transfer;
   logic [DW-1:0] sel_data;

`ifdef MUX_BURST_EN
   typedef enum logic {ST_ARB, ST_LOCK} state_t;
   localparam logic [7:0] BURST_LEN8 = 8'(BURST_LEN);

   state_t     state;
   logic [1:0] owner;
   logic [7:0] count;
`endif

   // The output register can take a new beat when it is empty or draining.
   assign accept_en = !out_valid_q || bus.out_ready;

   // Rotating priority search starting just after the last served requester.
   // k runs 1..4 so that the last served requester is checked last.
   always_comb begin
      logic [1:0] idx;
      gnt       = 2'd0;
      gnt_found = 1'b0;
      idx       = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_grant + 2'(k);
         if (!gnt_found && bus.req_valid[idx]) begin
            gnt       = idx;
            gnt_found = 1'b1;
         end
      end
`ifdef MUX_BURST_EN
      // While locked, the owner is the only eligible requester.
      if (state == ST_LOCK) begin
         gnt       = owner;
         gnt_found = bus.req_valid[owner];
      end
`endif
   end

   assign transfer      = accept_en && gnt_found;
   assign bus.req_ready = transfer ? (4'b0001 << gnt) : 4'b0000;

   always_comb begin
      sel_data = bus.y0;
      case (gnt)
         2'd0: sel_data = bus.y0;
         2'd1: sel_data = bus.y1;
         2'd2: sel_data = bus.y2;
         2'd3: sel_data = bus.y3;
         default: sel_data = bus.y0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= 2'd0;
         last_grant  <= 2'd3;
`ifdef MUX_BURST_EN
         state       <= ST_ARB;
         owner       <= 2'd0;
         count       <= 8'd0;
`endif
      end else begin
         if (transfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_sel_q   <= gnt;
            // In LOCK gnt is always the owner, so this also leaves
            // last_grant == owner when the burst ends.
            last_grant  <= gnt;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
`ifdef MUX_BURST_EN
         case (state)
            ST_ARB: begin
               if (transfer && (BURST_LEN8 > 8'd1)) begin
                  state <= ST_LOCK;
                  owner <= gnt;
                  count <= 8'd1;
               end
            end
            ST_LOCK: begin
               if (transfer) begin
                  if (count + 8'd1 == BURST_LEN8) begin
                     state <= ST_ARB;
                     count <= 8'd0;
                  end else begin
                     count <= count + 8'd1;
                  end
               end else if (accept_en && !bus.req_valid[owner]) begin
                  // Owner went idle while we could have taken a beat:
                  // give the channel back instead of stalling others.
                  state <= ST_ARB;
                  count <= 8'd0;
               end
            end
            default: begin
               state <= ST_ARB;
               count <= 8'd0;
            end
         endcase
`endif
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux64_rr_arbiter.sv
// tb/tb_mux64_rr_arbiter.sv - directed self-checking bench for mux64_rr_arbiter

module tb_mux64_rr_arbiter;

   localparam int DW = 64;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic [DW-1:0] yv [4];

   mux64_rr_arbiter_if #(.DW(DW)) bus ();

   mux64_rr_arbiter #(.DW(DW), .BURST_LEN(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data();
      bus.y0 = yv[0];
      bus.y1 = yv[1];
      bus.y2 = yv[2];
      bus.y3 = yv[3];
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) yv[i] = 64'hA000_0000_0000_0000 | 64'(i);
      set_data();
      bus.req_valid = 4'b0000;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
      end
      checks++;
      if (bus.out_data !== 64'd0) begin
         failures++;
         $display("FAIL reset_out_data got=%h exp=0", bus.out_data);
      end
      checks++;
      if (bus.out_sel !== 2'd0) begin
         failures++;
         $display("FAIL reset_out_sel got=%0d exp=0", bus.out_sel);
      end
      #3 rst_n = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready);
      end
   endtask

   // All four requesting, consumer always ready: grants 0,1,2,3,0.
   task automatic test_round_robin();
      int exp_sel;
      bus.req_valid = 4'b1111;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_sel = i % 4;
         #1;
         checks++;
         if (bus.req_ready !== (4'b0001 << exp_sel)) begin
            failures++;
            $display("FAIL rr_req_ready[%0d] got=%b exp_sel=%0d", i, bus.req_ready, exp_sel);
         end
         step();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(exp_sel) || bus.out_data !== yv[exp_sel]) begin
            failures++;
            $display("FAIL rr_beat[%0d] got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%h",
                     i, bus.out_valid, bus.out_sel, bus.out_data, exp_sel, yv[exp_sel]);
         end
      end
   endtask

   // Only requester 2 for three beats, then 0 and 2 together -> 0 wins.
   task automatic test_single_requester();
      bus.req_valid = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== yv[2]) begin
            failures++;
            $display("FAIL single_beat[%0d] got v=%b sel=%0d data=%h exp v=1 sel=2",
                     i, bus.out_valid, bus.out_sel, bus.out_data);
         end
      end
      bus.req_valid = 4'b0101;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL single_next_grant got=%b exp=0001", bus.req_ready);
      end
      step();
      checks++;
      if (bus.out_sel !== 2'd0 || bus.out_data !== yv[0]) begin
         failures++;
         $display("FAIL single_next_beat got sel=%0d data=%h exp sel=0 data=%h",
                  bus.out_sel, bus.out_data, yv[0]);
      end
   endtask

   // No requests after a beat: output drains, data/sel are retained.
   task automatic test_drain();
      bus.req_valid = 4'b0000;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL drain_req_ready got=%b exp=0000", bus.req_ready);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out_data !== yv[0] || bus.out_sel !== 2'd0) begin
            failures++;
            $display("FAIL drain[%0d] got v=%b sel=%0d data=%h exp v=0 sel=0 data=%h",
                     i, bus.out_valid, bus.out_sel, bus.out_data, yv[0]);
         end
      end
   endtask

   // Consumer stalls for five cycles holding a beat from requester 1.
   task automatic test_back_pressure();
      yv[1] = 64'hDEAD_BEEF_0000_0001;
      set_data();
      bus.req_valid = 4'b0010;
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL bp_first_grant got=%b exp=0010", bus.req_ready);
      end
      step();
      bus.out_ready = 1'b0;
      bus.req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hDEAD_BEEF_0000_0001 ||
             bus.out_sel !== 2'd1 || bus.req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_hold[%0d] got v=%b sel=%0d data=%h rdy=%b exp v=1 sel=1 data=deadbeef00000001 rdy=0000",
                     i, bus.out_valid, bus.out_sel, bus.out_data, bus.req_ready);
         end
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL bp_release_grant got=%b exp=0100", bus.req_ready);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== yv[2]) begin
         failures++;
         $display("FAIL bp_release_beat got v=%b sel=%0d data=%h exp v=1 sel=2 data=%h",
                  bus.out_valid, bus.out_sel, bus.out_data, yv[2]);
      end
   endtask

   // Asynchronous reset while the output holds a beat.
   task automatic test_reset_mid_stream();
      bus.req_valid = 4'b1111;
      bus.out_ready = 1'b1;
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd3) begin
         failures++;
         $display("FAIL rst_mid_pre got v=%b sel=%0d exp v=1 sel=3", bus.out_valid, bus.out_sel);
      end
      bus.req_valid = 4'b0000;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 64'd0 || bus.out_sel !== 2'd0) begin
         failures++;
         $display("FAIL rst_mid_async got v=%b sel=%0d data=%h exp v=0 sel=0 data=0",
                  bus.out_valid, bus.out_sel, bus.out_data);
      end
      step();
      #3 rst_n = 1'b1;
      bus.req_valid = 4'b1001;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL rst_mid_first_grant got=%b exp=0001", bus.req_ready);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== yv[0]) begin
         failures++;
         $display("FAIL rst_mid_first_beat got v=%b sel=%0d data=%h exp v=1 sel=0",
                  bus.out_valid, bus.out_sel, bus.out_data);
      end
   endtask

`ifdef MUX_BURST_EN
   task automatic pulse_reset();
      bus.req_valid = 4'b0000;
      #2 rst_n = 1'b0;
      step();
      #3 rst_n = 1'b1;
   endtask

   // BURST_LEN=4, all requesting: 0,0,0,0,1,1,1,1,2.
   task automatic test_burst();
      int exp_sel;
      pulse_reset();
      bus.req_valid = 4'b1111;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         exp_sel = i / 4;
         #1;
         checks++;
         if (bus.req_ready !== (4'b0001 << exp_sel)) begin
            failures++;
            $display("FAIL burst_req_ready[%0d] got=%b exp_sel=%0d", i, bus.req_ready, exp_sel);
         end
         step();
         checks++;
         if (bus.out_sel !== 2'(exp_sel) || bus.out_data !== yv[exp_sel]) begin
            failures++;
            $display("FAIL burst_beat[%0d] got sel=%0d exp sel=%0d", i, bus.out_sel, exp_sel);
         end
      end
   endtask

   // Owner 1 drops valid after two beats: early release, then 2 is granted.
   task automatic test_burst_early_release();
      pulse_reset();
      bus.req_valid = 4'b1111;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      checks++;
      if (bus.out_sel !== 2'd1) begin
         failures++;
         $display("FAIL early_pre got sel=%0d exp sel=1", bus.out_sel);
      end
      bus.req_valid = 4'b1101;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL early_release_cycle got=%b exp=0000", bus.req_ready);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL early_rearb got v=%b rdy=%b exp v=0 rdy=0100", bus.out_valid, bus.req_ready);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2) begin
         failures++;
         $display("FAIL early_next_beat got v=%b sel=%0d exp v=1 sel=2", bus.out_valid, bus.out_sel);
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      test_reset();
      test_round_robin();
      test_single_requester();
      test_drain();
      test_back_pressure();
      test_reset_mid_stream();
`ifdef MUX_BURST_EN
      test_burst();
      test_burst_early_release();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
